wlan_scrambler: RTL and testbench

Frame-based IEEE 802.11a transmit scrambler, the transmit-side counterpart of the existing descrambler. It sits between the SERVICE/PSDU bit source and the convolutional encoder. It XORs each data bit with the x^7+x^4+1 sequence from a per-frame seed, then appends six zero tail bits that bypass the scrambler. It reports frame progress with busy/done.

---
 rtl/wlan_scrambler.sv | 148 ++++++++++++++
 tb/tb_wlan_scrambler.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wlan_scrambler.sv
// ---------------------------------------------------------------------------
// wlan_scrambler
//
// Frame-based 802.11a transmit scrambler. It sits between the SERVICE/PSDU
// bit source and the convolutional encoder. Each data bit is XORed with the
// x^7 + x^4 + 1 sequence, starting from a per-frame seed. After the data bits,
// TAIL_BITS zero bits are appended. The tail bits bypass the scrambler so that
// the encoder is flushed back to its zero state.
//
// Parameters:
//   LEN_W         width of the frame bit-length field
//   TAIL_BITS     number of zero tail bits appended after the data
//   DEFAULT_SEED  LFSR seed used when the supplied seed is zero
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       one-cycle pulse; loads seed and len_bits, begins a frame
//   seed        initial LFSR state, sampled only with start
//   len_bits    number of data bits to scramble in this frame
//   din         serial data bit
//   din_valid   din is valid this cycle (consumed only while running)
//   dout        scrambled data bit or zero tail bit (registered)
//   dout_valid  dout is valid this cycle (registered)
//   busy        high while the frame is in progress
//   done        one-cycle pulse after the last tail bit
// ---------------------------------------------------------------------------
module wlan_scrambler #(
    parameter int         LEN_W        = 16,
    parameter int         TAIL_BITS    = 6,
    parameter logic [6:0] DEFAULT_SEED = 7'b1011101
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       seed,
    input  logic [LEN_W-1:0] len_bits,
    input  logic             din,
    input  logic             din_valid,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0]       TAIL_LAST = 3'(TAIL_BITS - 1);
    localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [6:0]       lfsr;
    logic [LEN_W-1:0] cnt;
    logic [2:0]       tail_cnt;
    logic             fb;

    // The feedback bit doubles as the keystream bit for the current data bit.
    assign fb = lfsr[6] ^ lfsr[3];

    // Next-state logic. In RUN the exit test uses <= 1 rather than == 1, so a
    // counter that is somehow zero while running still drains into the tail
    // instead of wrapping.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len_bits == '0) ? ST_TAIL : ST_RUN;
                end
            end
            ST_RUN: begin
                if (din_valid && (cnt <= CNT_ONE)) begin
                    state_next = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (tail_cnt == TAIL_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. Every output is recomputed on each
    // edge, so a stall cycle or an idle cycle drops dout_valid without any
    // extra bookkeeping. busy follows the next state, which makes it rise on
    // the first cycle after start and fall on the same cycle that done
    // pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lfsr       <= DEFAULT_SEED;
            cnt        <= '0;
            tail_cnt   <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != ST_IDLE);
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // An all-zero seed would lock the LFSR at zero.
                        lfsr     <= (seed == '0) ? DEFAULT_SEED : seed;
                        cnt      <= len_bits;
                        tail_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (din_valid) begin
                        dout       <= din ^ fb;
                        dout_valid <= 1'b1;
                        lfsr       <= {lfsr[5:0], fb};
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end
                ST_TAIL: begin
                    dout_valid <= 1'b1;
                    tail_cnt   <= tail_cnt + 3'd1;
                end
                ST_DONE: begin
                    done     <= 1'b1;
                    tail_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wlan_scrambler.sv
// ---------------------------------------------------------------------------
// tb_wlan_scrambler
//
// Self-checking bench for wlan_scrambler. Each frame driver pushes the
// expected output bits into a queue as it drives stimulus. The expected bits
// are the scrambled data bits followed by the zero tail bits. A monitor
// collects every valid output bit into a second queue. Each test task then
// pops both queues and compares them.
// ---------------------------------------------------------------------------
module tb_wlan_scrambler;

    localparam int         LEN_W     = 16;
    localparam int         TAIL_BITS = 6;
    localparam logic [6:0] DEF_SEED  = 7'b1011101;
    localparam logic [15:0] FIRST16  = 16'b0000111011110010;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [6:0]       seed;
    logic [LEN_W-1:0] len_bits;
    logic             din;
    logic             din_valid;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    int compared   = 0;
    int mismatched = 0;

    int cyc = 0;
    int start_cyc;
    int done_cyc;
    int first_valid_cyc;
    int last_valid_cyc;
    int valid_cnt;
    int done_cnt;
    bit busy_drop;

    logic       got_q[$];
    logic       exp_q[$];
    bit         frame_bits[$];
    logic [6:0] m_s;

    wlan_scrambler #(
        .LEN_W       (LEN_W),
        .TAIL_BITS   (TAIL_BITS),
        .DEFAULT_SEED(DEF_SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seed      (seed),
        .len_bits  (len_bits),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock and edge counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: sample away from the active edge and log every valid
    // bit plus the timing of the first and last valid bit and of done.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            got_q.push_back(dout);
            if (valid_cnt == 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
            valid_cnt++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Inputs change just after the falling edge, after the monitor has run.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drive one frame from frame_bits. The expected scrambled bits are pushed
    // as each bit is accepted. stall_pct is the percentage of cycles with
    // din_valid low. glitch_at (>= 0) pulses start again on that cycle of
    // the data phase.
    task automatic drive_frame(input logic [6:0] sd, input int len,
                               input int stall_pct, input int glitch_at);
        int   i;
        int   k;
        logic fb;
        got_q.delete();
        exp_q.delete();
        valid_cnt = 0;
        done_cnt  = 0;
        busy_drop = 0;
        m_s = (sd == 7'd0) ? DEF_SEED : sd;
        start    = 1'b1;
        seed     = sd;
        len_bits = 16'(len);
        tick();
        start     = 1'b0;
        start_cyc = cyc;
        seed      = 7'($urandom);
        len_bits  = 16'($urandom);
        i = 0;
        k = 0;
        while (i < len) begin
            if (busy !== 1'b1) busy_drop = 1;
            start     = (k == glitch_at);
            din       = frame_bits[i];
            din_valid = ($urandom_range(99) >= stall_pct);
            if (din_valid) begin
                fb = m_s[6] ^ m_s[3];
                exp_q.push_back(din ^ fb);
                m_s = {m_s[5:0], fb};
                i++;
            end
            tick();
            k++;
        end
        start     = 1'b0;
        din_valid = 1'b0;
        repeat (TAIL_BITS) exp_q.push_back(1'b0);
        k = 0;
        while (done_cnt == 0 && k < 100) begin
            tick();
            k++;
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        seed = '0;
        len_bits = '0;
        din = 1'b0;
        din_valid = 1'b1;
        tick();
        tick();
        compared++; if (dout !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dout got %b want 0", dout); end
        compared++; if (dout_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dout_valid got %b want 0", dout_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
        reset = 1'b0;
        valid_cnt = 0;
        repeat (5) begin din = 1'($urandom); tick(); end
        din_valid = 1'b0;
        compared++; if (valid_cnt != 0) begin mismatched++; $display("[TB] FAIL idle_din_ignored got %0d outputs want 0", valid_cnt); end
    endtask

    task automatic test_known_sequence();
        logic [15:0] head;
        int   ones;
        int   idx;
        logic e;
        logic g;
        frame_bits.delete();
        repeat (254) frame_bits.push_back(1'b0);
        drive_frame(7'h7F, 127, 0, -1);
        head = '0;
        ones = 0;
        for (int i = 0; i < 16 && i < got_q.size(); i++) head[15-i] = got_q[i];
        for (int i = 0; i < 127 && i < got_q.size(); i++) ones += int'(got_q[i]);
        compared++; if (head !== FIRST16) begin mismatched++; $display("[TB] FAIL seq_first16 got %b want %b", head, FIRST16); end
        compared++; if (ones != 64) begin mismatched++; $display("[TB] FAIL seq_ones got %0d want 64", ones); end
        compared++; if (valid_cnt != 133) begin mismatched++; $display("[TB] FAIL seq_count got %0d want 133", valid_cnt); end
        compared++; if (last_valid_cyc - first_valid_cyc + 1 != 133) begin mismatched++; $display("[TB] FAIL seq_contiguous span %0d want 133", last_valid_cyc - first_valid_cyc + 1); end
        compared++; if (done_cnt != 1) begin mismatched++; $display("[TB] FAIL seq_done_pulses got %0d want 1", done_cnt); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
            compared++; if (g !== e) begin mismatched++; $display("[TB] FAIL seq_bit %0d got %b want %b", idx, g, e); end
            idx++;
        end
        // A frame longer than the period must repeat the sequence at bit 128.
        drive_frame(7'h7F, 254, 0, -1);
        head = '0;
        for (int i = 0; i < 16 && (127 + i) < got_q.size(); i++) head[15-i] = got_q[127+i];
        compared++; if (head !== FIRST16) begin mismatched++; $display("[TB] FAIL seq_repeat got %b want %b", head, FIRST16); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
            compared++; if (g !== e) begin mismatched++; $display("[TB] FAIL seq_long_bit %0d got %b want %b", idx, g, e); end
            idx++;
        end
        compared++; if (got_q.size() != 0) begin mismatched++; $display("[TB] FAIL seq_extra got %0d extra want 0", got_q.size()); end
    endtask

    task automatic test_round_trip();
        logic [6:0] d_s;
        logic       fb;
        logic       e;
        logic       g;
        logic       r;
        frame_bits.delete();
        repeat (864) frame_bits.push_back(1'($urandom));
        drive_frame(DEF_SEED, 864, 0, -1);
        compared++; if (done_cyc - start_cyc != 871) begin mismatched++; $display("[TB] FAIL rt_done_latency got %0d want 871", done_cyc - start_cyc); end
        compared++; if (valid_cnt != 870) begin mismatched++; $display("[TB] FAIL rt_count got %0d want 870", valid_cnt); end
        d_s = DEF_SEED;
        for (int i = 0; i < 870; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
            compared++; if (g !== e) begin mismatched++; $display("[TB] FAIL rt_bit %0d got %b want %b", i, g, e); end
            if (i < 864) begin
                fb  = d_s[6] ^ d_s[3];
                r   = g ^ fb;
                d_s = {d_s[5:0], fb};
                compared++; if (r !== logic'(frame_bits[i])) begin mismatched++; $display("[TB] FAIL rt_recovered %0d got %b want %b", i, r, frame_bits[i]); end
            end
        end
    endtask

    task automatic test_stalls();
        int   idx;
        logic e;
        logic g;
        drive_frame(DEF_SEED, 864, 30, -1);
        compared++; if (busy_drop) begin mismatched++; $display("[TB] FAIL stall_busy got busy low want high"); end
        compared++; if (done_cnt != 1) begin mismatched++; $display("[TB] FAIL stall_done got %0d want 1", done_cnt); end
        compared++; if (valid_cnt != 870) begin mismatched++; $display("[TB] FAIL stall_count got %0d want 870", valid_cnt); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
            compared++; if (g !== e) begin mismatched++; $display("[TB] FAIL stall_bit %0d got %b want %b", idx, g, e); end
            idx++;
        end
    endtask

    task automatic test_boundaries();
        int   idx;
        logic e;
        logic g;
        // A zero seed must behave exactly like the default seed.
        frame_bits.delete();
        repeat (40) frame_bits.push_back(1'($urandom));
        drive_frame(7'd0, 40, 0, -1);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
            compared++; if (g !== e) begin mismatched++; $display("[TB] FAIL seed0_bit %0d got %b want %b", idx, g, e); end
            idx++;
        end
        // Empty frame: tail only.
        drive_frame(7'h33, 0, 0, -1);
        compared++; if (valid_cnt != 6) begin mismatched++; $display("[TB] FAIL len0_count got %0d want 6", valid_cnt); end
        compared++; if (first_valid_cyc - start_cyc != 1) begin mismatched++; $display("[TB] FAIL len0_first_tail got %0d want 1", first_valid_cyc - start_cyc); end
        compared++; if (done_cyc - start_cyc != 7) begin mismatched++; $display("[TB] FAIL len0_done got %0d want 7", done_cyc - start_cyc); end
        compared++; if (done_cnt != 1) begin mismatched++; $display("[TB] FAIL len0_done_pulses got %0d want 1", done_cnt); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
            compared++; if (g !== e) begin mismatched++; $display("[TB] FAIL len0_bit %0d got %b want %b", idx, g, e); end
            idx++;
        end
        // Single data bit.
        frame_bits.delete();
        frame_bits.push_back(1'b1);
        drive_frame(7'h45, 1, 0, -1);
        compared++; if (valid_cnt != 7) begin mismatched++; $display("[TB] FAIL len1_count got %0d want 7", valid_cnt); end
        compared++; if (done_cyc - start_cyc != 8) begin mismatched++; $display("[TB] FAIL len1_done got %0d want 8", done_cyc - start_cyc); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
            compared++; if (g !== e) begin mismatched++; $display("[TB] FAIL len1_bit %0d got %b want %b", idx, g, e); end
            idx++;
        end
    endtask

    task automatic test_start_ignored();
        int   idx;
        logic e;
        logic g;
        frame_bits.delete();
        repeat (20) frame_bits.push_back(1'($urandom));
        drive_frame(7'h5A, 20, 0, 5);
        compared++; if (valid_cnt != 26) begin mismatched++; $display("[TB] FAIL glitch_count got %0d want 26", valid_cnt); end
        compared++; if (done_cyc - start_cyc != 27) begin mismatched++; $display("[TB] FAIL glitch_done got %0d want 27", done_cyc - start_cyc); end
        compared++; if (done_cnt != 1) begin mismatched++; $display("[TB] FAIL glitch_done_pulses got %0d want 1", done_cnt); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
            compared++; if (g !== e) begin mismatched++; $display("[TB] FAIL glitch_bit %0d got %b want %b", idx, g, e); end
            idx++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int   idx;
        logic e;
        logic g;
        valid_cnt = 0;
        done_cnt  = 0;
        start    = 1'b1;
        seed     = 7'h55;
        len_bits = 16'd50;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = 1'($urandom);
            din_valid = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        compared++; if (dout_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_dout_valid got %b want 0", dout_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        compared++; if (dout !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_dout got %b want 0", dout); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_done got %b want 0", done); end
        reset = 1'b0;
        valid_cnt = 0;
        repeat (60) tick();
        din_valid = 1'b0;
        compared++; if (valid_cnt != 0) begin mismatched++; $display("[TB] FAIL midrst_outputs got %0d want 0", valid_cnt); end
        compared++; if (done_cnt != 0) begin mismatched++; $display("[TB] FAIL midrst_done_pulses got %0d want 0", done_cnt); end
        frame_bits.delete();
        repeat (30) frame_bits.push_back(1'($urandom));
        drive_frame(7'h2A, 30, 0, -1);
        compared++; if (done_cnt != 1) begin mismatched++; $display("[TB] FAIL postrst_done got %0d want 1", done_cnt); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 1'bx;
            compared++; if (g !== e) begin mismatched++; $display("[TB] FAIL postrst_bit %0d got %b want %b", idx, g, e); end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_known_sequence();
        test_round_trip();
        test_stalls();
        test_boundaries();
        test_start_ignored();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
